pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter stage for the 5-stage pipeline; successor to the basic PC register.
- Selects the next PC from three sources: sequential increment, branch/jump redirect, and exception/eret.
- Holds the PC on stall or disable; buffers one redirect that arrives while held, so a redirect is never lost.
- Keeps the EPC register that eret returns to.

Parameters:
- WIDTH, 32, PC/address width in bits.
- RESET_VECTOR, 32'h00400000, PC value on reset.
- EXC_VECTOR, 32'h00400004, exception handler entry address.
- INC, 4, sequential PC increment.

Ports:
- in_clk  input  1  clock; all state updates on rising edge.
- in_rst  input  1  asynchronous, active-high reset.
- in_ena  input  1  PC update enable; 0 = hold.
- in_stall  input  1  pipeline stall; 1 = hold.
- in_br_valid  input  1  branch/jump redirect request.
- in_br_target  input  WIDTH  branch/jump target.
- in_exc  input  1  exception request.
- in_exc_pc  input  WIDTH  faulting-instruction PC, saved to EPC.
- in_eret  input  1  return-from-exception request.
- out_pc  output  WIDTH  current PC.
- out_pc_plus  output  WIDTH  out_pc + INC, combinational, wraps modulo 2^WIDTH.
- out_epc  output  WIDTH  saved exception PC.
- out_pending  output  1  a buffered redirect is waiting.

Behaviour:
- Reset (async, in_rst=1):
  - out_pc = RESET_VECTOR, out_epc = 0, out_pending = 0.
  - Pending target and flags cleared.
  - Takes effect immediately, including mid-stall with a pending redirect; the pending redirect is discarded.
- Advance condition: adv = in_ena & ~in_stall.
- Request priority (same cycle): in_exc > in_eret > in_br_valid.
  - Exception target = EXC_VECTOR.
  - Eret target = current out_epc.
  - Branch target = in_br_target.
  - Target bits are used as given; no alignment masking.
- Next-PC selection when adv=1:
  1. Any new request this cycle: load the highest-priority new target. The new request overrides any pending entry. Pending is cleared.
  2. Else if out_pending=1: load the pending target and clear pending.
  3. Else: out_pc <= out_pc + INC.
- When adv=0:
  - out_pc holds.
  - If any request is present: capture the highest-priority one into the pending buffer (target, is_exc, exc_pc) and set out_pending=1. The effective eret target is captured at this time.
  - A later request overwrites the pending entry only if its priority is greater than or equal to the stored entry. A lower-priority request is dropped.
  - With no request, pending is unchanged.
- EPC update: out_epc <= exc_pc on the cycle the exception is applied to out_pc. Applied means adv=1 and the exception is either new or pending. Latching into pending does not update EPC. Eret does not modify EPC.
- Latency: one cycle from an applied request to out_pc showing the target. A pending redirect appears the cycle after adv first returns to 1.
- Wrap-around: out_pc at 2^WIDTH-INC advances to 0.
- No other state; no FSM beyond the one-entry pending buffer (empty/full).

Test Plan:
- Reset then 3 cycles with ena=1, stall=0 -> out_pc 0x00400000, 0x00400004, 0x00400008, 0x0040000C; out_pc_plus always +4.
- Stall=1 for 2 cycles, with br_valid=1 and target 0x00400100 in the first stall cycle -> out_pc holds and out_pending=1. On release, out_pc=0x00400100 the next cycle and out_pending=0.
- Same cycle exc=1 (exc_pc 0x00400020), eret=1, br_valid=1 with ena=1 -> out_pc=0x00400004 (EXC_VECTOR) and out_epc=0x00400020. Then eret alone -> out_pc=0x00400020.
- Branch pending during stall, then exc arrives while still stalled -> pending replaced. After release: out_pc=EXC_VECTOR and EPC updated. Reverse order (exc then branch) -> branch dropped and exception taken.
- Pending set, release cycle carries new br_valid target 0x00400200 -> out_pc=0x00400200 and pending cleared.
- WIDTH=16, RESET_VECTOR=16'hFFF8, INC=4 -> out_pc FFF8, FFFC, 0000. Assert in_rst mid-stall with pending set -> out_pc=FFF8 at once, out_pending=0, out_epc=0.

Source files
------------

// File: rtl/pc_unit.sv
// Program-counter stage: picks the next PC from increment, branch, exception or eret,
// and parks one redirect while the pipeline is held so it is applied on release.
module pc_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h00400000,
   parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'h00400004,
   parameter int               INC          = 4
) (
   input  logic             in_clk,
   input  logic             in_rst,
   input  logic             in_ena,
   input  logic             in_stall,
   input  logic             in_br_valid,
   input  logic [WIDTH-1:0] in_br_target,
   input  logic             in_exc,
   input  logic [WIDTH-1:0] in_exc_pc,
   input  logic             in_eret,
   output logic [WIDTH-1:0] out_pc,
   output logic [WIDTH-1:0] out_pc_plus,
   output logic [WIDTH-1:0] out_epc,
   output logic             out_pending
);

   localparam logic [WIDTH-1:0] INC_W     = WIDTH'(INC);
   localparam logic [1:0]       PRIO_BR   = 2'd0;
   localparam logic [1:0]       PRIO_ERET = 2'd1;
   localparam logic [1:0]       PRIO_EXC  = 2'd2;

   logic             adv;
   logic             req;
   logic [1:0]       req_prio;
   logic [WIDTH-1:0] req_target;

   logic [WIDTH-1:0] pend_target;
   logic [WIDTH-1:0] pend_exc_pc;
   logic [1:0]       pend_prio;

   assign adv         = in_ena & ~in_stall;
   assign req         = in_exc | in_eret | in_br_valid;
   assign out_pc_plus = out_pc + INC_W;

   // Eret resolves to the EPC value visible now, so a parked eret keeps that target.
   always_comb begin
      req_prio   = PRIO_BR;
      req_target = in_br_target;
      if (in_exc) begin
         req_prio   = PRIO_EXC;
         req_target = EXC_VECTOR;
      end else if (in_eret) begin
         req_prio   = PRIO_ERET;
         req_target = out_epc;
      end
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         out_pc      <= RESET_VECTOR;
         out_epc     <= '0;
         out_pending <= 1'b0;
         pend_target <= '0;
         pend_exc_pc <= '0;
         pend_prio   <= PRIO_BR;
      end else if (adv) begin
         if (req) begin
            out_pc      <= req_target;
            out_pending <= 1'b0;
            if (in_exc)
               out_epc <= in_exc_pc;
         end else if (out_pending) begin
            out_pc      <= pend_target;
            out_pending <= 1'b0;
            if (pend_prio == PRIO_EXC)
               out_epc <= pend_exc_pc;
         end else begin
            out_pc <= out_pc_plus;
         end
      end else if (req && (!out_pending || req_prio >= pend_prio)) begin
         // Held: equal or higher priority replaces the parked entry, lower is dropped.
         pend_target <= req_target;
         pend_exc_pc <= in_exc_pc;
         pend_prio   <= req_prio;
         out_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a 32-bit default instance and a 16-bit wrap-around instance,
// with expected results queued at drive time and popped when the outputs are sampled.
module tb_pc_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance
   logic        rst, ena, stall, brv, exc, eret;
   logic [31:0] brt, excpc;
   logic [31:0] pc, pc_plus, epc;
   logic        pend;

   pc_unit dut (
      .in_clk(clk), .in_rst(rst), .in_ena(ena), .in_stall(stall),
      .in_br_valid(brv), .in_br_target(brt), .in_exc(exc), .in_exc_pc(excpc),
      .in_eret(eret), .out_pc(pc), .out_pc_plus(pc_plus), .out_epc(epc),
      .out_pending(pend)
   );

   // 16-bit instance
   logic        rst_b, ena_b, stall_b, brv_b, exc_b, eret_b;
   logic [15:0] brt_b, excpc_b;
   logic [15:0] pc_b, pc_plus_b, epc_b;
   logic        pend_b;

   pc_unit #(.WIDTH(16), .RESET_VECTOR(16'hFFF8), .EXC_VECTOR(16'h0004), .INC(4)) dut_b (
      .in_clk(clk), .in_rst(rst_b), .in_ena(ena_b), .in_stall(stall_b),
      .in_br_valid(brv_b), .in_br_target(brt_b), .in_exc(exc_b), .in_exc_pc(excpc_b),
      .in_eret(eret_b), .out_pc(pc_b), .out_pc_plus(pc_plus_b), .out_epc(epc_b),
      .out_pending(pend_b)
   );

   typedef struct {
      string       tag;
      bit          is_b;
      logic [31:0] pc;
      logic [31:0] plus;
      logic [31:0] epc;
      logic        pend;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic push(input string tag, input bit is_b, input logic [31:0] p,
                       input logic [31:0] e, input logic pn);
      exp_t x;
      x.tag  = tag;
      x.is_b = is_b;
      x.pc   = p;
      x.plus = is_b ? {16'h0, 16'(p[15:0] + 16'd4)} : p + 32'd4;
      x.epc  = e;
      x.pend = pn;
      q.push_back(x);
   endtask

   task automatic check_front();
      exp_t        x;
      logic [31:0] a_pc, a_plus, a_epc;
      logic        a_pend;
      if (q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty got 0 entries need 1");
         return;
      end
      x = q.pop_front();
      if (x.is_b) begin
         a_pc = {16'h0, pc_b}; a_plus = {16'h0, pc_plus_b};
         a_epc = {16'h0, epc_b}; a_pend = pend_b;
      end else begin
         a_pc = pc; a_plus = pc_plus; a_epc = epc; a_pend = pend;
      end
      checks++;
      assert (a_pc === x.pc) else begin
         errors++;
         $error("FAIL %s.pc got %h need %h", x.tag, a_pc, x.pc);
      end
      checks++;
      assert (a_plus === x.plus) else begin
         errors++;
         $error("FAIL %s.pc_plus got %h need %h", x.tag, a_plus, x.plus);
      end
      checks++;
      assert (a_epc === x.epc) else begin
         errors++;
         $error("FAIL %s.epc got %h need %h", x.tag, a_epc, x.epc);
      end
      checks++;
      assert (a_pend === x.pend) else begin
         errors++;
         $error("FAIL %s.pending got %b need %b", x.tag, a_pend, x.pend);
      end
   endtask

   // one clock for instance A with expectation queued at drive time
   task automatic step_a(input string tag, input logic [31:0] p, input logic [31:0] e,
                         input logic pn);
      push(tag, 1'b0, p, e, pn);
      @(posedge clk); #1;
      check_front();
   endtask

   task automatic step_b(input string tag, input logic [15:0] p, input logic [15:0] e,
                         input logic pn);
      push(tag, 1'b1, {16'h0, p}, {16'h0, e}, pn);
      @(posedge clk); #1;
      check_front();
   endtask

   task automatic idle_a();
      brv = 0; exc = 0; eret = 0; stall = 0; ena = 1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog got timeout need finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; ena = 0; stall = 0; brv = 0; exc = 0; eret = 0; brt = '0; excpc = '0;
      rst_b = 1; ena_b = 0; stall_b = 0; brv_b = 0; exc_b = 0; eret_b = 0;
      brt_b = '0; excpc_b = '0;
      @(posedge clk); #1;
      push("reset", 0, 32'h00400000, 32'h0, 0);
      check_front();

      // sequential run
      rst = 0; ena = 1;
      step_a("seq1", 32'h00400004, 32'h0, 0);
      step_a("seq2", 32'h00400008, 32'h0, 0);
      step_a("seq3", 32'h0040000C, 32'h0, 0);

      // branch parked during stall
      stall = 1; brv = 1; brt = 32'h00400100;
      step_a("stall_br", 32'h0040000C, 32'h0, 1);
      brv = 0;
      step_a("stall_hold", 32'h0040000C, 32'h0, 1);
      stall = 0;
      step_a("release_br", 32'h00400100, 32'h0, 0);
      step_a("after_br", 32'h00400104, 32'h0, 0);

      // simultaneous requests: exception wins
      exc = 1; excpc = 32'h00400020; eret = 1; brv = 1; brt = 32'h00400300;
      step_a("prio_exc", 32'h00400004, 32'h00400020, 0);
      idle_a(); eret = 1;
      step_a("eret", 32'h00400020, 32'h00400020, 0);
      idle_a();
      step_a("after_eret", 32'h00400024, 32'h00400020, 0);

      // parked branch replaced by exception
      stall = 1; brv = 1; brt = 32'h00400300;
      step_a("park_br", 32'h00400024, 32'h00400020, 1);
      brv = 0; exc = 1; excpc = 32'h00400040;
      step_a("exc_over_br", 32'h00400024, 32'h00400020, 1);
      idle_a();
      step_a("release_exc", 32'h00400004, 32'h00400040, 0);

      // parked exception keeps priority over a later branch
      stall = 1; exc = 1; excpc = 32'h00400050;
      step_a("park_exc", 32'h00400004, 32'h00400040, 1);
      exc = 0; brv = 1; brt = 32'h00400300;
      step_a("br_dropped", 32'h00400004, 32'h00400040, 1);
      idle_a();
      step_a("release_exc2", 32'h00400004, 32'h00400050, 0);
      step_a("after_exc2", 32'h00400008, 32'h00400050, 0);

      // new branch on release overrides parked one
      stall = 1; brv = 1; brt = 32'h00400100;
      step_a("park_br2", 32'h00400008, 32'h00400050, 1);
      stall = 0; brv = 1; brt = 32'h00400200;
      step_a("new_overrides", 32'h00400200, 32'h00400050, 0);
      idle_a();
      step_a("after_new", 32'h00400204, 32'h00400050, 0);

      // disable holds; parked eret returns to EPC
      ena = 0;
      step_a("ena_hold", 32'h00400204, 32'h00400050, 0);
      ena = 1; stall = 1; eret = 1;
      step_a("park_eret", 32'h00400204, 32'h00400050, 1);
      idle_a();
      step_a("release_eret", 32'h00400050, 32'h00400050, 0);

      // 16-bit instance: wrap-around and async reset with pending
      push("b_reset", 1, 32'h0000FFF8, 32'h0, 0);
      check_front();
      rst_b = 0; ena_b = 1;
      step_b("b_seq1", 16'hFFFC, 16'h0000, 0);
      step_b("b_wrap", 16'h0000, 16'h0000, 0);
      exc_b = 1; excpc_b = 16'h00AA;
      step_b("b_exc", 16'h0004, 16'h00AA, 0);
      exc_b = 0; stall_b = 1; brv_b = 1; brt_b = 16'h1234;
      step_b("b_park", 16'h0004, 16'h00AA, 1);
      brv_b = 0;
      #2 rst_b = 1;
      #1;
      push("b_async_rst", 1, 32'h0000FFF8, 32'h0, 0);
      check_front();
      @(posedge clk); #1;
      rst_b = 0; stall_b = 0;
      step_b("b_discarded", 16'hFFFC, 16'h0000, 0);

      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_left got %0d need 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
